// File: rtl/fan_speed_commander_pkg.sv
// ============================================================================
// Module   : fan_pkg
// Brief    : Shared speed codes and commander FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fan_pkg;

    localparam int SPEED_W = 2;

    typedef logic [SPEED_W-1:0] speed_t;

    localparam speed_t SPD_OFF  = 2'b00;
    localparam speed_t SPD_LOW  = 2'b01;
    localparam speed_t SPD_MED  = 2'b10;
    localparam speed_t SPD_HIGH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PULSE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fan_speed_commander_if.sv
// ============================================================================
// Module   : fan_speed_commander_if
// Brief    : Target-speed valid/ready request channel into the commander.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fan_speed_commander_if #(
    parameter int SPEED_W = 2
);
    logic               target_valid;
    logic               target_ready;
    logic [SPEED_W-1:0] target_speed;

    modport master (
        output target_valid,
        output target_speed,
        input  target_ready
    );

    modport slave (
        input  target_valid,
        input  target_speed,
        output target_ready
    );
endinterface

`default_nettype wire

// File: rtl/fan_speed_commander_timer.sv
// ============================================================================
// Module   : fan_cmd_timer
// Brief    : Loadable down-counter; o_expired is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_cmd_timer #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_value,
    output logic                  o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fan_speed_commander.sv
// ============================================================================
// Module   : fan_speed_commander
// Brief    : Steps the fan regulator to a requested speed with spaced,
//            feedback-checked up/down pulses. Optional abort: FAN_CMD_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_speed_commander #(
    parameter int SPEED_W        = 2,
    parameter int MAX_SPEED      = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    fan_speed_commander_if.slave    req,
    input  wire logic [SPEED_W-1:0] fan_speed_in,
`ifdef FAN_CMD_ABORT_EN
    input  wire logic               abort,
`endif
    output logic                    up_out,
    output logic                    down_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    import fan_pkg::*;

    localparam int c_cnt_max = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [SPEED_W-1:0] c_max_spd = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] c_one     = SPEED_W'(1);

    state_t             r_state;
    logic [SPEED_W-1:0] r_tgt;
    logic [SPEED_W-1:0] r_expected;
    logic [SPEED_W-1:0] r_prev;
    logic               r_up;
    logic               r_down;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic [SPEED_W-1:0] w_req_spd;
    logic               w_ack;
    logic               w_at_tgt;
    logic               w_abort;
    logic               w_tmr_load;
    logic [c_cnt_w-1:0] w_tmr_value;
    logic               w_tmr_expired;

    assign w_req_spd = (req.target_speed > c_max_spd) ? c_max_spd : req.target_speed;
    assign w_ack     = (fan_speed_in == r_expected);
    assign w_at_tgt  = (fan_speed_in == r_tgt);

`ifdef FAN_CMD_ABORT_EN
    assign w_abort = abort && (r_state != ST_IDLE) && (r_state != ST_DONE);
`else
    assign w_abort = 1'b0;
`endif

    // Timeout window opens with each pulse; the gap window opens on a good intermediate step.
    assign w_tmr_load  = (r_state == ST_PULSE) ||
                         ((r_state == ST_WAIT_ACK) && w_ack && !w_at_tgt);
    assign w_tmr_value = (r_state == ST_PULSE) ? c_cnt_w'(TIMEOUT_CYCLES)
                                               : c_cnt_w'(GAP_CYCLES);

    fan_cmd_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tgt      <= '0;
            r_expected <= '0;
            r_prev     <= '0;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_up   <= 1'b0;
            r_down <= 1'b0;
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_error <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req.target_valid) begin
                            r_tgt   <= w_req_spd;
                            r_error <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= (w_req_spd == fan_speed_in) ? ST_DONE : ST_PULSE;
                        end
                    end
                    ST_PULSE: begin
                        // Direction is re-decided from live feedback, so a boundary is never overrun.
                        r_prev <= fan_speed_in;
                        if (r_tgt > fan_speed_in) begin
                            r_up       <= 1'b1;
                            r_expected <= fan_speed_in + c_one;
                            r_state    <= ST_WAIT_ACK;
                        end else if (r_tgt < fan_speed_in) begin
                            r_down     <= 1'b1;
                            r_expected <= fan_speed_in - c_one;
                            r_state    <= ST_WAIT_ACK;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (w_ack) begin
                            r_state <= w_at_tgt ? ST_DONE : ST_GAP;
                        end else if ((fan_speed_in != r_prev) || w_tmr_expired) begin
                            r_state <= ST_ERR;
                        end
                    end
                    ST_GAP: begin
                        if (w_tmr_expired) begin
                            r_state <= ST_PULSE;
                        end
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    ST_ERR: begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign req.target_ready = (r_state == ST_IDLE);
    assign up_out           = r_up;
    assign down_out         = r_down;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;

endmodule

`default_nettype wire

// File: tb/tb_fan_speed_commander.sv
// ============================================================================
// Module   : tb_fan_speed_commander
// Brief    : Directed bench for fan_speed_commander with a behavioural regulator.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fan_speed_commander;
    import fan_pkg::*;

    localparam int GAP = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fan_speed_commander_if #(.SPEED_W(2)) req_if ();

    logic [1:0] m_fan;
    logic       m_load;
    logic [1:0] m_load_val;
    logic       m_freeze;
    logic       up_out, down_out, busy, done, error;
`ifdef FAN_CMD_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int r_nup, r_ndn, r_mingap, r_len, r_first;

    fan_speed_commander #(
        .SPEED_W(2), .MAX_SPEED(3), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req_if.slave),
        .fan_speed_in (m_fan),
`ifdef FAN_CMD_ABORT_EN
        .abort        (abort),
`endif
        .up_out       (up_out),
        .down_out     (down_out),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // Regulator model: one step per pulse, saturating; optional freeze and preset.
    always @(posedge clk) begin
        if (m_load)
            m_fan <= m_load_val;
        else if (!m_freeze) begin
            if (up_out && m_fan != SPD_HIGH)
                m_fan <= m_fan + 2'd1;
            else if (down_out && m_fan != SPD_OFF)
                m_fan <= m_fan - 2'd1;
        end
    end

    task automatic set_fan(input logic [1:0] v);
        m_load = 1'b1; m_load_val = v;
        @(negedge clk);
        m_load = 1'b0;
    endtask

    task automatic request(input logic [1:0] spd);
        req_if.target_valid = 1'b1; req_if.target_speed = spd;
        @(negedge clk);
        req_if.target_valid = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int last;
        last = -1; r_nup = 0; r_ndn = 0; r_mingap = 1000; r_len = -1; r_first = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (up_out || down_out) begin
                n_checks++;
                if (up_out && down_out) begin
                    n_fail++; $display("FAIL pulse_overlap: up=%0b down=%0b required not both", up_out, down_out);
                end
                n_checks++;
                if ((up_out && m_fan == SPD_HIGH) || (down_out && m_fan == SPD_OFF)) begin
                    n_fail++; $display("FAIL pulse_at_boundary: fan=%0d up=%0b down=%0b", m_fan, up_out, down_out);
                end
                if (last >= 0 && (i - last) < r_mingap) r_mingap = i - last;
                last = i;
                if (r_first < 0) r_first = i;
                if (up_out) r_nup++; else r_ndn++;
            end
            if (done) begin
                r_len = i;
                break;
            end
        end
        n_checks++;
        if (r_len < 0) begin
            n_fail++; $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_fan(SPD_OFF);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({up_out, down_out, busy, done, error} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 00000", {up_out, down_out, busy, done, error});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_if.target_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", req_if.target_ready);
        end
    endtask

    task automatic test_up_full();
        set_fan(SPD_OFF);
        request(SPD_HIGH);
        run_until_done(60);
        n_checks++;
        if (r_nup !== 3 || r_ndn !== 0) begin
            n_fail++; $display("FAIL up_count: got up=%0d down=%0d required up=3 down=0", r_nup, r_ndn);
        end
        n_checks++;
        if (r_mingap < GAP + 1) begin
            n_fail++; $display("FAIL up_spacing: got %0d required >=%0d", r_mingap, GAP + 1);
        end
        n_checks++;
        if (m_fan !== SPD_HIGH || error !== 1'b0 || req_if.target_ready !== 1'b1) begin
            n_fail++; $display("FAIL up_final: fan=%0d err=%0b ready=%0b required 3 0 1", m_fan, error, req_if.target_ready);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL up_done_once: got %b required 0", done);
        end
    endtask

    task automatic test_down_full();
        set_fan(SPD_HIGH);
        request(SPD_OFF);
        run_until_done(60);
        n_checks++;
        if (r_ndn !== 3 || r_nup !== 0) begin
            n_fail++; $display("FAIL down_count: got up=%0d down=%0d required up=0 down=3", r_nup, r_ndn);
        end
        n_checks++;
        if (m_fan !== SPD_OFF || error !== 1'b0) begin
            n_fail++; $display("FAIL down_final: fan=%0d err=%0b required 0 0", m_fan, error);
        end
    endtask

    task automatic test_equal_target();
        set_fan(SPD_MED);
        request(SPD_MED);
        n_checks++;
        if ({busy, done, up_out, down_out} !== 4'b1000) begin
            n_fail++; $display("FAIL eq_cycle1: busy,done,up,dn=%b required 1000", {busy, done, up_out, down_out});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, up_out, down_out} !== 4'b0100) begin
            n_fail++; $display("FAIL eq_cycle2: busy,done,up,dn=%b required 0100", {busy, done, up_out, down_out});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00 || req_if.target_ready !== 1'b1) begin
            n_fail++; $display("FAIL eq_cycle3: busy,done=%b ready=%b required 00 1", {busy, done}, req_if.target_ready);
        end
    endtask

    task automatic test_timeout();
        set_fan(SPD_OFF);
        m_freeze = 1'b1;
        request(SPD_HIGH);
        run_until_done(60);
        n_checks++;
        if (r_nup !== 1 || error !== 1'b1) begin
            n_fail++; $display("FAIL tmo_result: up=%0d err=%0b required 1 1", r_nup, error);
        end
        n_checks++;
        if ((r_len - r_first) < TMO || (r_len - r_first) > TMO + 3) begin
            n_fail++; $display("FAIL tmo_latency: got %0d cycles required %0d..%0d", r_len - r_first, TMO, TMO + 3);
        end
        m_freeze = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL tmo_sticky: err=%0b done=%0b required 1 0", error, done);
        end
        request(SPD_OFF);
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL tmo_clear: got err=%0b required 0", error);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrong_direction();
        set_fan(SPD_LOW);
        request(SPD_HIGH);
        @(negedge clk);
        n_checks++;
        if (up_out !== 1'b1) begin
            n_fail++; $display("FAIL wrong_first_pulse: got up=%0b required 1", up_out);
        end
        m_load = 1'b1; m_load_val = SPD_OFF;
        @(negedge clk);
        m_load = 1'b0;
        run_until_done(10);
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL wrong_dir_error: got %b required 1", error);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        set_fan(SPD_OFF);
        request(SPD_HIGH);
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            @(negedge clk);
            if (up_out) seen = 1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({up_out, down_out, busy, done, error} !== 5'b0 || req_if.target_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_outputs: got %b ready=%b required 00000 1", {up_out, down_out, busy, done, error}, req_if.target_ready);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (up_out || down_out) seen++;
        end
        n_checks++;
        if (seen !== 0 || m_fan !== SPD_LOW) begin
            n_fail++; $display("FAIL midreset_quiet: pulses=%0d fan=%0d required 0 1", seen, m_fan);
        end
    endtask

    task automatic test_back_to_back();
        set_fan(SPD_OFF);
        request(SPD_MED);
        // A second request arrives while busy and must be dropped.
        req_if.target_valid = 1'b1; req_if.target_speed = SPD_OFF;
        fork
            begin
                repeat (4) @(negedge clk);
                req_if.target_valid = 1'b0;
            end
        join_none
        run_until_done(60);
        n_checks++;
        if (r_nup !== 2 || m_fan !== SPD_MED || error !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore: up=%0d fan=%0d err=%0b required 2 2 0", r_nup, m_fan, error);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef FAN_CMD_ABORT_EN
    task automatic test_abort();
        int seen;
        set_fan(SPD_OFF);
        request(SPD_HIGH);
        @(negedge clk);
        n_checks++;
        if (up_out !== 1'b1) begin
            n_fail++; $display("FAIL abort_first_pulse: got up=%0b required 1", up_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({done, error, up_out, down_out} !== 4'b1000 || req_if.target_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_outputs: done,err,up,dn=%b ready=%b required 1000 1", {done, error, up_out, down_out}, req_if.target_ready);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (up_out || down_out) seen++;
        end
        n_checks++;
        if (seen !== 0 || m_fan !== SPD_LOW) begin
            n_fail++; $display("FAIL abort_quiet: pulses=%0d fan=%0d required 0 1", seen, m_fan);
        end
    endtask
`endif

    initial begin
        req_if.target_valid = 1'b0;
        req_if.target_speed = SPD_OFF;
        m_load = 1'b0; m_load_val = SPD_OFF; m_freeze = 1'b0;
`ifdef FAN_CMD_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_up_full();
        test_down_full();
        test_equal_target();
        test_timeout();
        test_wrong_direction();
        test_reset_mid();
        test_back_to_back();
`ifdef FAN_CMD_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fan_speed_commander.md
Name: fan_speed_commander

Overview:
- Initiator side of the fan regulator's up/down command interface.
- Accepts a target speed over a valid/ready request port and drives single-cycle up or down pulses into the regulator until the regulator's fan_speed feedback equals the target.
- Pulse spacing is enforced; each step is checked against the feedback, with a timeout.
- Sits between the system controller and the fan regulator; its up_out/down_out connect to the regulator's up_in/down_in.

Parameters:
SPEED_W, 2, width of speed codes (00 OFF, 01 LOW, 10 MED, 11 HIGH)
MAX_SPEED, 3, highest legal speed code; requested targets above it are clamped to it
GAP_CYCLES, 4, idle cycles forced between consecutive pulses (min 1)
TIMEOUT_CYCLES, 16, max cycles to wait for feedback to move after a pulse (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
target_valid  input  1  request strobe
target_ready  output  1  high only in IDLE
target_speed  input  SPEED_W  requested speed
fan_speed_in  input  SPEED_W  regulator feedback (fan_speed_out of regulator)
up_out  output  1  one-cycle increment pulse
down_out  output  1  one-cycle decrement pulse
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
error  output  1  sticky fault flag

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; ports are clk and reset.
- Reset values: state IDLE, up_out=0, down_out=0, done=0, error=0, busy=0. target_ready=1 from the first edge after reset is taken.
- All outputs are registered except target_ready, which is decoded from state.
- Accept: target_valid && target_ready at edge N latches tgt = min(target_speed, MAX_SPEED) and clears error.
  - If tgt == fan_speed_in, go to DONE.
  - Otherwise go to PULSE.
- target_valid while busy is ignored; the request is not queued.
- FSM states: IDLE, PULSE, WAIT_ACK, GAP, DONE, ERR.
- PULSE: for exactly one cycle, assert up_out if tgt > fan_speed_in, else down_out. Latch expected = fan_speed_in ±1. Load the timer with TIMEOUT_CYCLES. Go to WAIT_ACK.
  - First pulse is high in cycle N+1 after accept.
- WAIT_ACK: compare fan_speed_in each cycle.
  - fan_speed_in == expected and == tgt: go to DONE.
  - fan_speed_in == expected and != tgt: load timer with GAP_CYCLES, go to GAP.
  - fan_speed_in differs from both expected and its pre-pulse value (wrong direction or jump): go to ERR.
  - Timer expires with no change: go to ERR.
- GAP: up_out/down_out low. When the timer expires, go to PULSE, re-deciding direction from the current feedback.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 (held until the next accept), done=1 for one cycle, then IDLE.
- Invariants:
  - up_out and down_out are never high together.
  - No pulse is issued while the regulator is at a boundary in the pulse direction: no up_out at 11, no down_out at 00.
  - Pulses are never on consecutive cycles; at least GAP_CYCLES+1 cycles separate them.
- Reset mid-operation: the next edge returns all outputs to reset values and the in-flight request is dropped.
- Arithmetic: expected is computed in SPEED_W bits. Boundary cases never reach PULSE, so no wrap occurs.

Optional Feature:
- Macro: FAN_CMD_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort high in any state other than IDLE or DONE: next edge clears up_out/down_out, pulses done=1 with error=0, goes to IDLE.
  - The remaining steps are not issued.
  - abort in IDLE has no effect.
- Undefined: no abort port; a request always runs to DONE or ERR.

Decomposition:
- Package fan_pkg:
  - speed typedef (logic [SPEED_W-1:0])
  - constants SPD_OFF=2'b00, SPD_LOW=2'b01, SPD_MED=2'b10, SPD_HIGH=2'b11
  - FSM state enum; shared later with the regulator and its bench
- One sub-module: fan_cmd_timer, a loadable down-counter with an expire flag, used for both GAP and TIMEOUT.

Test Plan:
- Reset, fan at 00, request 11 → up_out pulses exactly 3 times, at least 5 cycles apart; fan goes 01→10→11; done pulses once, error=0, target_ready returns to 1.
- Fan at 11, request 00 → 3 down_out pulses; feedback 10→01→00; done=1, error=0.
- Fan at 10, request 10 → no pulses; done asserted 2 cycles after accept; busy high for exactly 1 cycle.
- Model holds feedback frozen after the first pulse → error=1 and done=1 after TIMEOUT_CYCLES; error stays 1 until the next accept clears it.
- Reset asserted during GAP of a 00→11 request → outputs 0 next edge; target_ready=1; no further pulses.
- With FAN_CMD_ABORT_EN: abort during WAIT_ACK of a 00→11 request → done=1, error=0, IDLE; fan stays at 01.
